// File: rtl/qarctan_arbiter.sv
// qarctan_arbiter: shares one qarctan angle unit between N_REQ requesters.
// Requests are granted round-robin, or by fixed priority when the macro
// QARCTAN_ARB_FIXED_PRIO_EN is defined. Each granted operand pair is held on
// the qarctan inputs until the next grant. The result is returned to the
// originating requester over a backpressured response port.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both high. req_ready is a function of state and
// req_valid only. rsp_valid, rsp_data and rsp_id stay constant until the
// matching rsp_ready bit is seen.
module qarctan_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_SIZE = 32,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DATA_SIZE-1:0] req_real,
  input  logic [N_REQ*DATA_SIZE-1:0] req_imag,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [DATA_SIZE-1:0]       rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       qa_start,
  output logic [DATA_SIZE-1:0]       qa_real,
  output logic [DATA_SIZE-1:0]       qa_imag,
  input  logic [DATA_SIZE-1:0]       qa_data_out,
  input  logic                       qa_done,
  output logic                       busy,
  output logic                       spurious_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ID_W-1:0]      cur_id;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_found;
  logic [DATA_SIZE-1:0] op_real;
  logic [DATA_SIZE-1:0] op_imag;
  logic [DATA_SIZE-1:0] res;
  logic                 accept;
  logic                 rsp_fire;

`ifdef QARCTAN_ARB_FIXED_PRIO_EN
  // Grant selection: the lowest asserted index wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] last;

  // Grant selection: search upward from last+1, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(last) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(last) + k) % N_REQ);
      end
    end
  end

  // Rotation pointer: remembers the requester served most recently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= ID_W'(N_REQ - 1);
    end else if (rsp_fire) begin
      last <= cur_id;
    end
  end
`endif

  assign accept   = (state == S_IDLE) && grant_found;
  assign rsp_fire = (state == S_RESP) && rsp_ready[cur_id];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    qa_start  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        qa_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (qa_done) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid[cur_id] = 1'b1;
        if (rsp_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, result and status registers. The operands change only on an
  // accept, because qarctan samples them again late in its computation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_real       <= '0;
      op_imag       <= '0;
      cur_id        <= '0;
      res           <= '0;
      spurious_done <= 1'b0;
    end else begin
      if (accept) begin
        op_real <= req_real[int'(grant_id) * DATA_SIZE +: DATA_SIZE];
        op_imag <= req_imag[int'(grant_id) * DATA_SIZE +: DATA_SIZE];
        cur_id  <= grant_id;
      end
      if ((state == S_WAIT) && qa_done) res <= qa_data_out;
      if ((state != S_WAIT) && qa_done) spurious_done <= 1'b1;
    end
  end

  assign qa_real  = op_real;
  assign qa_imag  = op_imag;
  assign rsp_data = res;
  assign rsp_id   = cur_id;

endmodule
